// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer write/read ports.
// Holds the port FSM state encoding and the buffer pixel-count helper.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } fb_state_t;

    function automatic int pixel_count(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Registered y*WIDTH+x linear address stage with valid/flag/data passthrough.
// Inputs must already be in range; the read side reuses this stage unchanged.
module fb_addr_calc #(
    parameter int CORDW = 16,
    parameter int WIDTH = 320,
    parameter int ADDRW = 16,
    parameter int DATAW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_flag,
    input  logic [CORDW-1:0] in_x,
    input  logic [CORDW-1:0] in_y,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    output logic             out_flag,
    output logic [ADDRW-1:0] out_addr,
    output logic [DATAW-1:0] out_data
);

    logic [ADDRW-1:0] x_a;
    logic [ADDRW-1:0] y_a;
    logic [ADDRW-1:0] w_a;

    assign x_a = ADDRW'(in_x);
    assign y_a = ADDRW'(in_y);
    assign w_a = ADDRW'(WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_flag  <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid & ~flush;
            out_flag  <= in_flag;
            out_addr  <= y_a * w_a + x_a;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/fb_write_port.sv
// Framebuffer write port: frame-start clear FSM, pixel clipping and BRAM write port.
// Optional macro FB_WRITE_STATS_EN adds saturating written/clipped pixel counters.
module fb_write_port
    import fb_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 180,
    parameter int CIDXW  = 4,
    localparam int ADDRW = $clog2(WIDTH*HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             clear_en,
    input  logic [CIDXW-1:0] bgidx,
    input  logic             we,
    input  logic [CORDW-1:0] x,
    input  logic [CORDW-1:0] y,
    input  logic [CIDXW-1:0] cidx,
    output logic             busy,
    output logic             wready,
    output logic             clip,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [CIDXW-1:0] mem_data
`ifdef FB_WRITE_STATS_EN
    ,
    output logic [31:0]      stat_written,
    output logic [31:0]      stat_clipped
`endif
);

    localparam int PIXELS = pixel_count(WIDTH, HEIGHT);
    localparam logic signed [CORDW-1:0] WIDTH_S  = CORDW'(WIDTH);
    localparam logic signed [CORDW-1:0] HEIGHT_S = CORDW'(HEIGHT);
    localparam logic [ADDRW:0] LAST_CNT = (ADDRW+1)'(PIXELS);

    fb_state_t        state;
    logic [ADDRW:0]   clr_cnt;
    logic             clr_we;
    logic [ADDRW-1:0] clr_addr;
    logic [CIDXW-1:0] clr_data;

    logic                    s1_valid;
    logic signed [CORDW-1:0] s1_x;
    logic signed [CORDW-1:0] s1_y;
    logic [CIDXW-1:0]        s1_cidx;
    logic                    s1_out;
    logic [CORDW-1:0]        s1_x_safe;
    logic [CORDW-1:0]        s1_y_safe;

    logic             s2_valid;
    logic             s2_out;
    logic [ADDRW-1:0] s2_addr;
    logic [CIDXW-1:0] s2_data;
    logic             pix_we;

    // frame_start always wins: it re-samples the clear settings and restarts from address 0.
    // The first clear write is issued on the frame_start edge so the clear spans exactly PIXELS cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b1;
            wready   <= 1'b0;
            clr_cnt  <= '0;
            clr_we   <= 1'b0;
            clr_addr <= '0;
            clr_data <= '0;
        end else if (frame_start) begin
            clr_data <= bgidx;
            clr_addr <= '0;
            if (clear_en) begin
                state   <= CLEAR;
                busy    <= 1'b1;
                wready  <= 1'b0;
                clr_we  <= 1'b1;
                clr_cnt <= (ADDRW+1)'(1);
            end else begin
                state   <= READY;
                busy    <= 1'b0;
                wready  <= 1'b1;
                clr_we  <= 1'b0;
                clr_cnt <= '0;
            end
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST_CNT) begin
                        state  <= READY;
                        busy   <= 1'b0;
                        wready <= 1'b1;
                        clr_we <= 1'b0;
                    end else begin
                        clr_we   <= 1'b1;
                        clr_addr <= clr_cnt[ADDRW-1:0];
                        clr_cnt  <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    clr_we <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_cidx  <= '0;
        end else begin
            s1_valid <= we & ~busy & ~frame_start;
            s1_x     <= x;
            s1_y     <= y;
            s1_cidx  <= cidx;
        end
    end

    assign s1_out = (s1_x < 0) | (s1_x >= WIDTH_S) | (s1_y < 0) | (s1_y >= HEIGHT_S);

    // Out-of-range coordinates are zeroed so the multiplier only ever sees in-range values.
    assign s1_x_safe = s1_out ? '0 : s1_x;
    assign s1_y_safe = s1_out ? '0 : s1_y;

    fb_addr_calc #(
        .CORDW (CORDW),
        .WIDTH (WIDTH),
        .ADDRW (ADDRW),
        .DATAW (CIDXW)
    ) u_addr_calc (
        .clk       (clk),
        .rst       (rst),
        .flush     (frame_start),
        .in_valid  (s1_valid),
        .in_flag   (s1_out),
        .in_x      (s1_x_safe),
        .in_y      (s1_y_safe),
        .in_data   (s1_cidx),
        .out_valid (s2_valid),
        .out_flag  (s2_out),
        .out_addr  (s2_addr),
        .out_data  (s2_data)
    );

    // Clear writes and pixel writes never overlap, so a plain mux feeds the single BRAM port.
    assign pix_we   = s2_valid & ~s2_out;
    assign clip     = s2_valid & s2_out;
    assign mem_we   = clr_we | pix_we;
    assign mem_addr = clr_we ? clr_addr : s2_addr;
    assign mem_data = clr_we ? clr_data : s2_data;

`ifdef FB_WRITE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_written <= '0;
            stat_clipped <= '0;
        end else if (frame_start) begin
            stat_written <= '0;
            stat_clipped <= '0;
        end else begin
            if (pix_we && (stat_written != 32'hFFFF_FFFF)) begin
                stat_written <= stat_written + 32'd1;
            end
            if (clip && (stat_clipped != 32'hFFFF_FFFF)) begin
                stat_clipped <= stat_clipped + 32'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule
